// File: rtl/updi_block_writer.sv
// Serialises one decoded program block into the UPDI write sequence: ST PTR, REPEAT, ST *(ptr++).
// Define UPDI_ACK_CHECK_EN to add ACK checking after the address and after every data byte.
module updi_block_writer #(
    parameter int unsigned DATA_BLOCK_MAX_SIZE = 16,
    parameter int unsigned ACK_TIMEOUT         = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    output logic                             o_ready,
    output logic                             o_done,
    input  logic [7:0]                       i_block_length,
    input  logic [15:0]                      i_block_address,
    input  logic [7:0]                       i_block_type,
    input  logic [8*DATA_BLOCK_MAX_SIZE-1:0] i_block_data,
    output logic [7:0]                       o_tx_data,
    output logic                             o_tx_valid,
    input  logic                             i_tx_ready
`ifdef UPDI_ACK_CHECK_EN
    ,
    input  logic [7:0]                       i_rx_data,
    input  logic                             i_rx_valid,
    output logic                             o_error
`endif
);

    localparam int unsigned IDX_W   = $clog2(DATA_BLOCK_MAX_SIZE);
    localparam logic [7:0]  MAX_LEN = 8'(DATA_BLOCK_MAX_SIZE);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PTR_SYNC = 4'd1;
    localparam logic [3:0] S_PTR_OP   = 4'd2;
    localparam logic [3:0] S_ADDR_LO  = 4'd3;
    localparam logic [3:0] S_ADDR_HI  = 4'd4;
    localparam logic [3:0] S_RPT_SYNC = 4'd5;
    localparam logic [3:0] S_RPT_OP   = 4'd6;
    localparam logic [3:0] S_RPT_CNT  = 4'd7;
    localparam logic [3:0] S_ST_SYNC  = 4'd8;
    localparam logic [3:0] S_ST_OP    = 4'd9;
    localparam logic [3:0] S_DATA     = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;
`ifdef UPDI_ACK_CHECK_EN
    localparam logic [3:0] S_PTR_ACK  = 4'd12;
    localparam logic [3:0] S_DATA_ACK = 4'd13;

    localparam int unsigned TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_error;
    logic             w_in_ack;
    logic             w_ack_ok;
    logic             w_ack_bad;
`endif

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [7:0]  r_len;
    logic [15:0] r_addr;
    logic [7:0]  r_data [DATA_BLOCK_MAX_SIZE];
    logic [7:0]  r_idx;
    logic [7:0]  w_len;
    logic        w_skip;
    logic        w_acc;
    logic        w_last;

    assign w_len   = (i_block_length > MAX_LEN) ? MAX_LEN : i_block_length;
    assign w_skip  = (i_block_type != 8'd0) || (w_len == 8'd0);
    assign w_acc   = o_tx_valid && i_tx_ready;
    assign w_last  = (r_idx == r_len - 8'd1);
    assign o_ready = (r_state == S_IDLE);
    assign o_done  = (r_state == S_DONE);

`ifdef UPDI_ACK_CHECK_EN
    assign w_in_ack  = (r_state == S_PTR_ACK) || (r_state == S_DATA_ACK);
    assign w_ack_ok  = i_rx_valid && (i_rx_data == 8'h40);
    assign w_ack_bad = (i_rx_valid && (i_rx_data != 8'h40)) || (!i_rx_valid && (r_tmo == TMO_LAST));
    assign o_error   = r_error;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next = w_skip ? S_DONE : S_PTR_SYNC;
            S_PTR_SYNC: if (w_acc) w_next = S_PTR_OP;
            S_PTR_OP:   if (w_acc) w_next = S_ADDR_LO;
            S_ADDR_LO:  if (w_acc) w_next = S_ADDR_HI;
`ifdef UPDI_ACK_CHECK_EN
            S_ADDR_HI:  if (w_acc) w_next = S_PTR_ACK;
            S_PTR_ACK: begin
                if (w_ack_bad)     w_next = S_DONE;
                else if (w_ack_ok) w_next = S_RPT_SYNC;
            end
            S_DATA:     if (w_acc) w_next = S_DATA_ACK;
            // r_idx has already advanced past the byte being acknowledged
            S_DATA_ACK: begin
                if (w_ack_bad)     w_next = S_DONE;
                else if (w_ack_ok) w_next = (r_idx == r_len) ? S_DONE : S_DATA;
            end
`else
            S_ADDR_HI:  if (w_acc) w_next = S_RPT_SYNC;
            S_DATA:     if (w_acc) w_next = w_last ? S_DONE : S_DATA;
`endif
            S_RPT_SYNC: if (w_acc) w_next = S_RPT_OP;
            S_RPT_OP:   if (w_acc) w_next = S_RPT_CNT;
            S_RPT_CNT:  if (w_acc) w_next = S_ST_SYNC;
            S_ST_SYNC:  if (w_acc) w_next = S_ST_OP;
            S_ST_OP:    if (w_acc) w_next = S_DATA;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h00;
        case (r_state)
            S_PTR_SYNC: o_tx_data = 8'h55;
            S_PTR_OP:   o_tx_data = 8'h69;
            S_ADDR_LO:  o_tx_data = r_addr[7:0];
            S_ADDR_HI:  o_tx_data = r_addr[15:8];
            S_RPT_SYNC: o_tx_data = 8'h55;
            S_RPT_OP:   o_tx_data = 8'hA0;
            S_RPT_CNT:  o_tx_data = r_len - 8'd1;
            S_ST_SYNC:  o_tx_data = 8'h55;
            S_ST_OP:    o_tx_data = 8'h64;
            S_DATA:     o_tx_data = r_data[r_idx[IDX_W-1:0]];
            default:    o_tx_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= 8'd0;
            r_addr  <= 16'd0;
            r_idx   <= 8'd0;
            for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++) r_data[i] <= 8'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) begin
                r_len  <= w_len;
                r_addr <= i_block_address;
                r_idx  <= 8'd0;
                for (int i = 0; i < DATA_BLOCK_MAX_SIZE; i++) r_data[i] <= i_block_data[8*i +: 8];
            end else if (r_state == S_DATA && w_acc) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

`ifdef UPDI_ACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            r_tmo <= w_in_ack ? r_tmo + 1'b1 : '0;
            if (r_state == S_IDLE && i_start) r_error <= 1'b0;
            else if (w_in_ack && w_ack_bad)   r_error <= 1'b1;
        end
    end
`endif

endmodule
